// File: rtl/sram_lsu.sv
// Load/store front-end for sram_4k: a request is accepted in IDLE, one ACCESS cycle reads, merges and writes, and the response is valid one edge after accept.
// The response is held until rsp_ready_in is high. FRISCV_LSU_MISALIGN_ERR_EN makes misaligned half/word accesses return an error instead of being force-aligned.
module sram_lsu #(
    parameter int ARCH      = 32,
    parameter int RAM_DEPTH = 4096,
    localparam int AW       = $clog2(RAM_DEPTH)
) (
    input  logic            clk,
    input  logic            rstn_in,
    input  logic            req_valid_in,
    output logic            req_ready_out,
    input  logic            req_we_in,
    input  logic [1:0]      req_size_in,
    input  logic            req_unsigned_in,
    input  logic [AW-1:0]   req_addr_in,
    input  logic [ARCH-1:0] req_wdata_in,
    output logic            rsp_valid_out,
    input  logic            rsp_ready_in,
    output logic [ARCH-1:0] rsp_rdata_out,
    output logic            rsp_err_out,
    output logic [AW-1:0]   addr_a_byte_out,
    output logic [ARCH-1:0] din_a_out,
    output logic            we_a_out,
    output logic [AW-1:0]   addr_b_byte_out,
    input  logic [ARCH-1:0] dout_b_in
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t          r_state;
    logic            r_req_ready;
    logic            r_rsp_valid;
    logic [ARCH-1:0] r_rdata;
    logic            r_we;
    logic [1:0]      r_size;
    logic            r_uns;
    logic [AW-1:0]   r_addr;
    logic [ARCH-1:0] r_wdata;

    logic [1:0]      w_lane;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [ARCH-1:0] w_load;
    logic [ARCH-1:0] w_merge;
    logic [AW-1:0]   w_req_addr;
    logic            w_to_err;
    logic            w_access_st;

`ifdef FRISCV_LSU_MISALIGN_ERR_EN
    logic r_err;

    // Misaligned requests bypass ACCESS so they can never touch memory.
    assign w_to_err   = ((req_size_in == 2'b01) && req_addr_in[0]) ||
                        (req_size_in[1] && (req_addr_in[1:0] != 2'b00));
    assign w_req_addr = req_addr_in;
    assign rsp_err_out = r_err;
`else
    always_comb begin
        w_req_addr = req_addr_in;
        case (req_size_in)
            2'b00:   w_req_addr = req_addr_in;
            2'b01:   w_req_addr = {req_addr_in[AW-1:1], 1'b0};
            default: w_req_addr = {req_addr_in[AW-1:2], 2'b00};
        endcase
    end
    assign w_to_err    = 1'b0;
    assign rsp_err_out = 1'b0;
`endif

    assign w_lane = r_addr[1:0];
    assign w_byte = dout_b_in[{w_lane, 3'b000} +: 8];
    assign w_half = r_addr[1] ? dout_b_in[31:16] : dout_b_in[15:0];

    always_comb begin
        w_load = '0;
        case (r_size)
            2'b00:   w_load = {{(ARCH-8){w_byte[7] & ~r_uns}}, w_byte};
            2'b01:   w_load = {{(ARCH-16){w_half[15] & ~r_uns}}, w_half};
            default: w_load = dout_b_in;
        endcase
    end

    // Sub-word stores merge into the word currently read on port B.
    always_comb begin
        w_merge = dout_b_in;
        case (r_size)
            2'b00:   w_merge[{w_lane, 3'b000} +: 8]     = r_wdata[7:0];
            2'b01:   w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_merge = r_wdata;
        endcase
    end

    assign w_access_st     = (r_state == S_ACCESS) && r_we;
    assign we_a_out        = w_access_st;
    assign din_a_out       = w_access_st ? w_merge : '0;
    assign addr_a_byte_out = r_addr;
    assign addr_b_byte_out = r_addr;
    assign req_ready_out   = r_req_ready;
    assign rsp_valid_out   = r_rsp_valid;
    assign rsp_rdata_out   = r_rdata;

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
`ifdef FRISCV_LSU_MISALIGN_ERR_EN
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_in) begin
                        r_we        <= req_we_in;
                        r_size      <= req_size_in;
                        r_uns       <= req_unsigned_in;
                        r_addr      <= w_req_addr;
                        r_wdata     <= req_wdata_in;
                        r_req_ready <= 1'b0;
                        r_rdata     <= '0;
`ifdef FRISCV_LSU_MISALIGN_ERR_EN
                        r_err       <= w_to_err;
`endif
                        r_state     <= w_to_err ? S_RESP : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_rdata     <= r_we ? '0 : w_load;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    // Error path arrives here straight from IDLE; valid rises one edge later.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready_in) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
